// File: rtl/jt053246_drq_pkg.sv
// Shared types and constants for the 053246 draw-request queue.
// Entry layout matches the field order the line drawer consumes (MSB = code).
package jt053246_drq_pkg;

  localparam int unsigned DRQ_EW = 56;

  // Debug read selectors, decoded from st_addr[0]
  localparam bit DRQ_ST_DEPTH = 1'b0;
  localparam bit DRQ_ST_OVF   = 1'b1;

  typedef struct packed {
    logic [15:0] code;
    logic [9:0]  attr;
    logic        hflip;
    logic        vflip;
    logic [8:0]  hpos;
    logic [3:0]  ysub;
    logic [11:0] hzoom;
    logic        hz_keep;
    logic [1:0]  shd;
  } drq_entry_t;

endpackage

// File: rtl/jt053246_drq_fifo.sv
// Circular command store for the draw-request queue: pointers, count and a
// dual-port style RAM (write on push, asynchronous read at rd_ptr).
module jt053246_drq_fifo
  import jt053246_drq_pkg::*;
#(
  parameter int unsigned AW = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cen,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic        i_flush,
  input  drq_entry_t  i_wr_ent,
  output drq_entry_t  o_rd_ent,
  output logic [AW:0] o_count_nxt,
  output logic        o_full,
  output logic        o_empty
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW:0] DepthC = (AW + 1)'(Depth);

  drq_entry_t    r_mem [Depth];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_full, r_empty;
  logic          w_wr_en, w_rd_en;

  assign w_wr_en = i_push & ~r_full & ~i_flush;
  assign w_rd_en = i_pop & ~r_empty & ~i_flush;

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (i_flush) begin
      // Drop everything queued; the write pointer keeps its place
      w_rd_ptr_nxt = r_wr_ptr;
      w_count_nxt  = '0;
    end else begin
      if (w_wr_en) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
      if (w_rd_en) w_rd_ptr_nxt = r_rd_ptr + 1'b1;
      unique case ({w_wr_en, w_rd_en})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (i_cen) begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == DepthC);
      r_empty  <= (w_count_nxt == '0);
    end
  end

  // RAM contents survive reset; only valid entries are ever read
  always_ff @(posedge i_clk) begin
    if (i_cen && w_wr_en) r_mem[r_wr_ptr] <= i_wr_ent;
  end

  assign o_rd_ent    = r_mem[r_rd_ptr];
  assign o_count_nxt = w_count_nxt;
  assign o_full      = r_full;
  assign o_empty     = r_empty;

endmodule

// File: rtl/jt053246_drq.sv
// Draw-request queue and dispatcher between the 053246 scanner and the line drawer.
// Define JT053246_DRQ_STATS_EN to build the peak-depth / overflow debug counters.
module jt053246_drq
  import jt053246_drq_pkg::*;
#(
  parameter int unsigned AW = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cen,
  input  logic              i_line_start,
  input  logic              i_vs,
  input  logic              i_push,
  input  logic [DRQ_EW-1:0] i_push_ent,
  output logic              o_full,
  output logic              o_pending,
  output logic              o_dr_start,
  input  logic              i_dr_busy,
  output logic [15:0]       o_code,
  output logic [9:0]        o_attr,
  output logic              o_hflip,
  output logic              o_vflip,
  output logic [8:0]        o_hpos,
  output logic [3:0]        o_ysub,
  output logic [11:0]       o_hzoom,
  output logic              o_hz_keep,
  output logic [1:0]        o_shd,
  input  logic [7:0]        i_st_addr,
  output logic [7:0]        o_st_dout
);

  drq_entry_t  w_wr_ent, w_rd_ent;
  drq_entry_t  r_cmd;
  logic [AW:0] w_count_nxt;
  logic        w_full, w_empty;
  logic        w_push, w_pop;
  logic        r_dr_start, r_pending;

  assign w_wr_ent = drq_entry_t'(i_push_ent);
  assign w_push   = i_push & ~i_line_start;
  // Blocking on r_dr_start leaves a dead cen after each start, covering busy-rise latency
  assign w_pop    = ~w_empty & ~i_dr_busy & ~r_dr_start & ~i_line_start;

  jt053246_drq_fifo #(
    .AW (AW)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cen       (i_cen),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (i_line_start),
    .i_wr_ent    (w_wr_ent),
    .o_rd_ent    (w_rd_ent),
    .o_count_nxt (w_count_nxt),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dr_start <= 1'b0;
      r_pending  <= 1'b0;
      r_cmd      <= '0;
    end else if (i_cen) begin
      r_dr_start <= w_pop;
      r_pending  <= (w_count_nxt != '0) | i_dr_busy | w_pop;
      if (w_pop) r_cmd <= w_rd_ent;
    end
  end

  assign o_full     = w_full;
  assign o_pending  = r_pending;
  assign o_dr_start = r_dr_start;
  assign o_code     = r_cmd.code;
  assign o_attr     = r_cmd.attr;
  assign o_hflip    = r_cmd.hflip;
  assign o_vflip    = r_cmd.vflip;
  assign o_hpos     = r_cmd.hpos;
  assign o_ysub     = r_cmd.ysub;
  assign o_hzoom    = r_cmd.hzoom;
  assign o_hz_keep  = r_cmd.hz_keep;
  assign o_shd      = r_cmd.shd;

`ifdef JT053246_DRQ_STATS_EN
  logic [AW:0] r_max_depth;
  logic [7:0]  r_ovf_cnt;
  logic [7:0]  r_st_dout;
  logic        r_vs_l;
  logic        w_vs_rise, w_drop;
  logic        w_unused;

  assign w_vs_rise = i_vs & ~r_vs_l;
  assign w_drop    = i_push & w_full & ~i_line_start;
  assign w_unused  = ^i_st_addr[7:1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_max_depth <= '0;
      r_ovf_cnt   <= '0;
      r_st_dout   <= '0;
      r_vs_l      <= 1'b0;
    end else if (i_cen) begin
      r_vs_l    <= i_vs;
      r_st_dout <= (i_st_addr[0] == DRQ_ST_OVF) ? r_ovf_cnt : 8'(r_max_depth);
      if (w_vs_rise) begin
        r_max_depth <= '0;
        r_ovf_cnt   <= '0;
      end else begin
        if (w_count_nxt > r_max_depth) r_max_depth <= w_count_nxt;
        if (w_drop && (r_ovf_cnt != 8'hff)) r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
    end
  end

  assign o_st_dout = r_st_dout;
`else
  logic w_unused;

  assign w_unused  = ^{i_vs, i_st_addr};
  assign o_st_dout = '0;
`endif

endmodule

// File: tb/tb_jt053246_drq.sv
// Self-checking bench for jt053246_drq: directed scenarios plus a randomized run
// compared every cycle against a queue-based behavioural model.
module tb_jt053246_drq;
  import jt053246_drq_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cen = 1'b1;
  logic        line_start = 1'b0;
  logic        vs = 1'b0;
  logic        push = 1'b0;
  logic [55:0] push_ent = '0;
  logic        dr_busy = 1'b0;
  logic [7:0]  st_addr = '0;

  logic        o_full, o_pending, o_dr_start, o_hflip, o_vflip, o_hz_keep;
  logic [15:0] o_code;
  logic [9:0]  o_attr;
  logic [8:0]  o_hpos;
  logic [3:0]  o_ysub;
  logic [11:0] o_hzoom;
  logic [1:0]  o_shd;
  logic [7:0]  o_st_dout;

  jt053246_drq #(.AW(3)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cen        (cen),
    .i_line_start (line_start),
    .i_vs         (vs),
    .i_push       (push),
    .i_push_ent   (push_ent),
    .o_full       (o_full),
    .o_pending    (o_pending),
    .o_dr_start   (o_dr_start),
    .i_dr_busy    (dr_busy),
    .o_code       (o_code),
    .o_attr       (o_attr),
    .o_hflip      (o_hflip),
    .o_vflip      (o_vflip),
    .o_hpos       (o_hpos),
    .o_ysub       (o_ysub),
    .o_hzoom      (o_hzoom),
    .o_hz_keep    (o_hz_keep),
    .o_shd        (o_shd),
    .i_st_addr    (st_addr),
    .o_st_dout    (o_st_dout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  drq_entry_t mq[$];
  drq_entry_t m_cmd = '0;
  logic       m_start = 1'b0, m_full = 1'b0, m_pending = 1'b0, m_vs_l = 1'b0;
  logic [7:0] m_st = '0;
  int         m_max = 0, m_ovf = 0;

  task automatic model_reset();
    mq.delete();
    m_cmd = '0; m_start = 1'b0; m_full = 1'b0; m_pending = 1'b0;
    m_st = '0; m_max = 0; m_ovf = 0; m_vs_l = 1'b0;
  endtask

  task automatic model_step();
    bit was_full, pop;
    was_full = (mq.size() == DEPTH);
    pop = (mq.size() != 0) && !dr_busy && !m_start && !line_start;
`ifdef JT053246_DRQ_STATS_EN
    m_st = st_addr[0] ? 8'(m_ovf) : 8'(m_max);
`endif
    if (line_start) mq.delete();
    else begin
      if (pop) m_cmd = mq.pop_front();
      if (push && !was_full) mq.push_back(drq_entry_t'(push_ent));
    end
    m_start   = pop;
    m_full    = (mq.size() == DEPTH);
    m_pending = (mq.size() != 0) || dr_busy || pop;
`ifdef JT053246_DRQ_STATS_EN
    if (vs && !m_vs_l) begin
      m_max = 0;
      m_ovf = 0;
    end else begin
      if (mq.size() > m_max) m_max = mq.size();
      if (push && was_full && !line_start && m_ovf < 255) m_ovf++;
    end
    m_vs_l = vs;
`endif
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else if (cen) model_step();
  end

  // One compare process: all outputs against the model on every falling edge
  initial begin
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      check("dr_start", o_dr_start, m_start);
      check("full", o_full, m_full);
      check("pending", o_pending, m_pending);
      check("fields", {o_code, o_attr, o_hflip, o_vflip, o_hpos, o_ysub, o_hzoom, o_hz_keep, o_shd},
            m_cmd);
      check("st_dout", o_st_dout, m_st);
    end
  end

  // ---------------- drawer emulator and pulse monitor ----------------
  logic auto_busy = 1'b0, rnd_len = 1'b0, drw_prev = 1'b0, mon_prev = 1'b0;
  int   blen = 4, busy_cnt = 0, cyc = 0;
  logic [15:0] pulses[$];
  int          ptimes[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    if (auto_busy) begin
      if (o_dr_start && !drw_prev) busy_cnt = rnd_len ? int'($urandom_range(0, 5)) : blen;
      else if (busy_cnt > 0) busy_cnt--;
      dr_busy = (busy_cnt > 0);
    end
    drw_prev = o_dr_start;
  end

  initial forever begin
    @(negedge clk);
    if (o_dr_start && !mon_prev) begin
      pulses.push_back(o_code);
      ptimes.push_back(cyc);
    end
    mon_prev = o_dr_start;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  function automatic logic [55:0] rand_ent();
    return 56'({$urandom(), $urandom()});
  endfunction

  task automatic do_push(input logic [55:0] e);
    push = 1'b1;
    push_ent = e;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (o_pending && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, o_pending, 1'b0);
  endtask

  logic [15:0] codes[$];
  drq_entry_t  e;
  logic [7:0]  st_exp;
  int          n_ok;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dr_start", o_dr_start, 1'b0);
    check("reset_full", o_full, 1'b0);
    check("reset_pending", o_pending, 1'b0);
    rst_n = 1'b1;

    // 1: stream, asynchronous reset mid-stream, then first command latency
    for (int i = 0; i < 3; i++) do_push(rand_ent());
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dr_start", o_dr_start, 1'b0);
    check("midrst_pending", o_pending, 1'b0);
    check("midrst_code", o_code, 16'h0);
    check("midrst_st", o_st_dout, 8'h0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    e = drq_entry_t'(rand_ent());
    e.code = 16'h1234;
    do_push(e);
    check("t1_no_start_yet", o_dr_start, 1'b0);
    check("t1_pending", o_pending, 1'b1);
    @(negedge clk);
    check("t1_start", o_dr_start, 1'b1);
    check("t1_code", o_code, 16'h1234);
    @(negedge clk);
    check("t1_start_clear", o_dr_start, 1'b0);
    check("t1_idle", o_pending, 1'b0);

    // 2: fill to full with the drawer busy, ninth push dropped
    dr_busy = 1'b1;
    codes.delete();
    for (int i = 0; i < 8; i++) begin
      e = drq_entry_t'(rand_ent());
      codes.push_back(e.code);
      do_push(e);
    end
    check("t2_full", o_full, 1'b1);
    st_addr = 8'h01;
    do_push(rand_ent());
    check("t2_still_full", o_full, 1'b1);
    repeat (2) @(negedge clk);
`ifdef JT053246_DRQ_STATS_EN
    st_exp = 8'd1;
`else
    st_exp = 8'd0;
`endif
    check("t2_ovf", o_st_dout, st_exp);

    // 3: drain with 4-cycle busy per command, FIFO order and spacing
    pulses.delete();
    ptimes.delete();
    blen = 4;
    auto_busy = 1'b1;
    wait_idle("t3_drain", 300);
    check("t3_count", pulses.size(), 8);
    for (int i = 0; i < 8 && i < pulses.size(); i++) check("t3_order", pulses[i], codes[i]);
    for (int i = 1; i < ptimes.size(); i++) check("t3_gap", ptimes[i] - ptimes[i-1] >= 2, 1'b1);

    // 4: steady push+pop at count 3, wrapping the pointers
    auto_busy = 1'b0;
    dr_busy = 1'b1;
    @(negedge clk);
    pulses.delete();
    codes.delete();
    for (int i = 0; i < 3; i++) begin
      e = drq_entry_t'(rand_ent());
      codes.push_back(e.code);
      do_push(e);
    end
    for (int i = 0; i < 10; i++) begin
      dr_busy = 1'b0;
      e = drq_entry_t'(rand_ent());
      codes.push_back(e.code);
      do_push(e);
      dr_busy = 1'b1;
      @(negedge clk);
    end
    check("t4_not_full", o_full, 1'b0);
    check("t4_pending", o_pending, 1'b1);
    check("t4_pops_in_loop", pulses.size(), 10);
    dr_busy = 1'b0;
    wait_idle("t4_drain", 50);
    check("t4_count", pulses.size(), 13);
    n_ok = 0;
    for (int i = 0; i < 13 && i < pulses.size(); i++) if (pulses[i] == codes[i]) n_ok++;
    check("t4_order", n_ok, 13);

    // 5: flush with 5 queued plus same-cen push, in-flight command kept
    blen = 20;
    auto_busy = 1'b1;
    e = drq_entry_t'(rand_ent());
    e.code = 16'hbeef;
    do_push(e);
    repeat (2) @(negedge clk);
    pulses.delete();
    for (int i = 0; i < 5; i++) do_push(rand_ent());
    line_start = 1'b1;
    do_push(rand_ent());
    line_start = 1'b0;
    check("t5_full", o_full, 1'b0);
    check("t5_no_start", o_dr_start, 1'b0);
    check("t5_busy_pending", o_pending, 1'b1);
    check("t5_inflight", o_code, 16'hbeef);
    wait_idle("t5_drain", 60);
    check("t5_no_pulses", pulses.size(), 0);

    // 6: peak-depth stat, cleared by a vs rise
    auto_busy = 1'b0;
    dr_busy = 1'b1;
    vs = 1'b1;
    @(negedge clk) vs = 1'b0;
    for (int i = 0; i < 6; i++) do_push(rand_ent());
    st_addr = 8'h00;
    repeat (3) @(negedge clk);
`ifdef JT053246_DRQ_STATS_EN
    st_exp = 8'd6;
`else
    st_exp = 8'd0;
`endif
    check("t6_peak", o_st_dout, st_exp);
    line_start = 1'b1;
    @(negedge clk) line_start = 1'b0;
    vs = 1'b1;
    @(negedge clk) vs = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_cleared", o_st_dout, 8'd0);
    dr_busy = 1'b0;

    // Randomized run
    rnd_len = 1'b1;
    auto_busy = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      cen        = ($urandom_range(0, 3) != 0);
      push       = ($urandom_range(0, 1) == 1);
      push_ent   = rand_ent();
      line_start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) vs = ~vs;
      st_addr    = 8'($urandom());
      @(negedge clk);
    end
    cen = 1'b1;
    push = 1'b0;
    line_start = 1'b0;
    wait_idle("final_drain", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
